// File: rtl/ecc_pkg.sv
// ecc_pkg: shared FSM state encoding and codeword constants for the ECC memory sequencer
package ecc_pkg;
    localparam int HALF_W = 16;
    localparam logic [2:0] FLAG_OK = 3'b000;
    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, CAPT, RESP} state_t;
endpackage

// File: rtl/ecc_mem_sequencer_if.sv
// ecc_mem_sequencer_if: request, dual-memory, decoder and response signals of the sequencer
interface ecc_mem_sequencer_if #(parameter int ADDR_W = 8);
    import ecc_pkg::*;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic [HALF_W-1:0] enc_up, enc_down;
    logic              mem_en, mem_we;
    logic [HALF_W-1:0] mem_wdata_up, mem_wdata_down, mem_rdata_up, mem_rdata_down;
    logic [HALF_W-1:0] dec_up, dec_down, dec_data;
    logic [2:0]        dec_flag;
    logic              rsp_valid, rsp_ready;
    logic [HALF_W-1:0] rsp_data;
    logic [2:0]        rsp_flag;
    logic [15:0]       err_count;
    modport slave (
        input  req_valid, req_write, req_addr, enc_up, enc_down, mem_rdata_up, mem_rdata_down,
               dec_data, dec_flag, rsp_ready,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata_up, mem_wdata_down,
               dec_up, dec_down, rsp_valid, rsp_data, rsp_flag, err_count
    );
    modport master (
        output req_valid, req_write, req_addr, enc_up, enc_down, mem_rdata_up, mem_rdata_down,
               dec_data, dec_flag, rsp_ready,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata_up, mem_wdata_down,
               dec_up, dec_down, rsp_valid, rsp_data, rsp_flag, err_count
    );
endinterface

// File: rtl/ecc_rd_wait_counter.sv
// ecc_rd_wait_counter: 3-bit loadable down-counter that parks at zero and flags it
module ecc_rd_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [2:0] i_val,
    output logic       o_zero
);
    logic [2:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_dec && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
    end
    assign o_zero = r_cnt == 3'd0;
endmodule

// File: rtl/ecc_mem_sequencer.sv
// ecc_mem_sequencer: sequences ECC codeword writes/reads over two 16-bit memories and a decoder
module ecc_mem_sequencer
    import ecc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rst_n,
    ecc_mem_sequencer_if.slave bus
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [HALF_W-1:0] r_wup, r_wdown, r_dec_up, r_dec_down, r_rsp_data;
    logic [2:0]        r_rsp_flag;
    logic [15:0]       r_err_count;
    logic              w_zero, w_accept;

    assign w_accept = bus.req_valid && r_state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.req_valid ? (bus.req_write ? WRITE : READ) : IDLE;
            WRITE:   w_next = IDLE;
            READ:    w_next = WAIT;
            WAIT:    w_next = w_zero ? CAPT : WAIT;
            CAPT:    w_next = RESP;
            RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // counter is loaded during READ so WAIT lasts exactly RD_LAT cycles
    ecc_rd_wait_counter u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (r_state == READ),
        .i_dec  (r_state == WAIT),
        .i_val  (3'(RD_LAT - 1)),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wup       <= '0;
            r_wdown     <= '0;
            r_dec_up    <= '0;
            r_dec_down  <= '0;
            r_rsp_data  <= '0;
            r_rsp_flag  <= '0;
            r_err_count <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wup   <= bus.enc_up;
                r_wdown <= bus.enc_down;
            end
            if (r_state == WAIT && w_zero) begin
                r_dec_up   <= bus.mem_rdata_up;
                r_dec_down <= bus.mem_rdata_down;
            end
            if (r_state == CAPT) begin
                r_rsp_data <= bus.dec_data;
                r_rsp_flag <= bus.dec_flag;
                if (bus.dec_flag != FLAG_OK && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.req_ready      = r_state == IDLE;
    assign bus.mem_en         = r_state == WRITE || r_state == READ;
    assign bus.mem_we         = r_state == WRITE;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata_up   = r_wup;
    assign bus.mem_wdata_down = r_wdown;
    assign bus.dec_up         = r_dec_up;
    assign bus.dec_down       = r_dec_down;
    assign bus.rsp_valid      = r_state == RESP;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_flag       = r_rsp_flag;
    assign bus.err_count      = r_err_count;
endmodule

// File: tb/tb_ecc_mem_sequencer.sv
// tb_ecc_mem_sequencer: directed plus random transactions against a memory/decoder model and scoreboard
module tb_ecc_mem_sequencer;
    localparam int RD_LAT = 2;
    localparam logic [15:0] DKEY = 16'h8BAD;

    logic clk, rst_n;
    logic [2:0] dflag;
    int vecs = 0, errs = 0;

    ecc_mem_sequencer_if #(.ADDR_W(8)) bus ();
    ecc_mem_sequencer #(.ADDR_W(8), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // two memories with an RD_LAT-deep read pipeline; idle slots return garbage
    logic [15:0] mem_up [256];
    logic [15:0] mem_dn [256];
    logic [31:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_up[bus.mem_addr] <= bus.mem_wdata_up;
            mem_dn[bus.mem_addr] <= bus.mem_wdata_down;
        end
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? {mem_up[bus.mem_addr], mem_dn[bus.mem_addr]} : 32'hDEADBEEF;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {bus.mem_rdata_up, bus.mem_rdata_down} = pipe[RD_LAT-1];
    assign bus.dec_data = bus.dec_up ^ bus.dec_down ^ DKEY;
    assign bus.dec_flag = dflag;

    // scoreboard: last written halves per address and expected error count
    logic [15:0] ref_up [256];
    logic [15:0] ref_dn [256];
    logic [15:0] ref_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] up, input logic [15:0] dn);
        chk("wr_ready", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = a; bus.enc_up = up; bus.enc_down = dn;
        @(negedge clk);
        bus.req_valid = 0; bus.req_addr = ~a; bus.enc_up = ~up; bus.enc_down = ~dn;
        chk("wr_strobe", {bus.mem_en, bus.mem_we, bus.rsp_valid, bus.req_ready}, 4'b1100);
        chk("wr_addr", bus.mem_addr, a);
        chk("wr_data", {bus.mem_wdata_up, bus.mem_wdata_down}, {up, dn});
        ref_up[a] = up;
        ref_dn[a] = dn;
        @(negedge clk);
        chk("wr_done", {bus.req_ready, bus.mem_en, bus.mem_we, bus.rsp_valid}, 4'b1000);
        chk("wr_addr_hold", bus.mem_addr, a);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [2:0] f, input int hold, input bit keep);
        int lat = 0;
        int strobes = 0;
        logic [15:0] exp_d;
        chk("rd_ready", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = a; dflag = f;
        do begin
            @(negedge clk);
            lat++;
            if (!keep) begin
                bus.req_valid = 0;
                bus.req_addr = ~a;
            end
            strobes += int'(bus.mem_en);
            if (lat == 1) chk("rd_strobe", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, a});
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end while (!bus.rsp_valid && lat < 20);
        bus.rsp_ready = 0;
        exp_d = ref_up[a] ^ ref_dn[a] ^ DKEY;
        if (f != 3'b000 && ref_err != 16'hFFFF) ref_err++;
        chk("rd_latency", lat, RD_LAT + 3);
        chk("rd_strobes", strobes, 1);
        chk("rd_dec", {bus.dec_up, bus.dec_down}, {ref_up[a], ref_dn[a]});
        chk("rd_data", bus.rsp_data, exp_d);
        chk("rd_flag", bus.rsp_flag, f);
        chk("err_count", bus.err_count, ref_err);
        chk("rd_mem_idle", {bus.mem_en, bus.mem_we, bus.req_ready}, 3'b000);
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_hold", {bus.rsp_valid, bus.req_ready, bus.mem_en, bus.rsp_flag, bus.rsp_data},
                {1'b1, 1'b0, 1'b0, f, exp_d});
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
        chk("rsp_done", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; dflag = 0; ref_err = 0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0;
        bus.enc_up = 0; bus.enc_down = 0; bus.rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("reset_ctrl", {bus.req_ready, bus.mem_en, bus.mem_we, bus.rsp_valid}, 4'b1000);
        chk("reset_data", {bus.dec_up, bus.dec_down, bus.rsp_data, bus.mem_addr}, 64'h0);
        chk("reset_err", {bus.err_count, bus.rsp_flag}, 19'h0);

        do_write(8'h05, 16'hA5A5, 16'h3C3C);
        do_read(8'h05, 3'b000, 0, 0);
        chk("known_data", bus.rsp_data, 16'h1234);
        do_read(8'h05, 3'b001, 4, 0);

        for (int i = 0; i < 16; i++) do_write(8'(i), 16'($urandom), 16'($urandom));
        for (int n = 0; n < 30; n++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) do_write(a, 16'($urandom), 16'($urandom));
            else do_read(a, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                         int'($urandom_range(0, 3)), 0);
        end

        do_read(8'h03, 3'b000, 2, 1);
        do_read(8'h03, 3'b100, 0, 0);

        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 8'h05; dflag = 3'b010;
        @(negedge clk);
        bus.req_valid = 0;
        @(negedge clk);
        chk("wait_quiet", {bus.mem_en, bus.rsp_valid, bus.req_ready}, 3'b000);
        rst_n = 0;
        #1;
        ref_err = 0;
        chk("rst_async", {bus.req_ready, bus.mem_en, bus.mem_we, bus.rsp_valid}, 4'b1000);
        chk("rst_regs", {bus.dec_up, bus.dec_down, bus.rsp_data, bus.mem_addr}, 64'h0);
        chk("rst_err", bus.err_count, ref_err);
        @(negedge clk);
        rst_n = 1;
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_rsp", {bus.rsp_valid, bus.mem_en, bus.req_ready}, 3'b001);
        end
        do_write(8'h05, 16'hA5A5, 16'h3C3C);
        do_read(8'h05, 3'b000, 1, 0);
        chk("post_rst_data", bus.rsp_data, 16'h1234);

        force dut.r_err_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_err_count;
        ref_err = 16'hFFFE;
        @(negedge clk);
        chk("preload", bus.err_count, ref_err);
        do_read(8'h07, 3'b011, 0, 0);
        do_read(8'h08, 3'b111, 0, 0);
        do_read(8'h09, 3'b001, 1, 0);
        chk("saturated", bus.err_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
